// File: rtl/proc_ctrl_pkg.sv
// Shared processor-control definitions: memory opcodes, MEM-stage state
// encoding and the default access timeout.
package proc_ctrl_pkg;

  localparam logic [3:0] OP_LOAD         = 4'b0000;
  localparam logic [3:0] OP_STORE        = 4'b0010;
  localparam int         TIMEOUT_DEFAULT = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_e;

  function automatic logic isMemOp(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts data-memory wait cycles and flags the last allowed one; the count
// saturates at TIMEOUT-1 so it can never wrap back into a "fresh" access.
module mem_wait_timer #(
  parameter int TIMEOUT = 8,
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign expired_o = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expired_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_stage_control.sv
// MEM pipeline stage controller: issues data-memory strobes for LOAD/STORE,
// stalls upstream while waiting, and aborts accesses that never complete.
module mem_stage_control
  import proc_ctrl_pkg::*;
#(
  parameter int IR_W    = 8,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [IR_W-1:0] ir3,
  input  logic            ir3_valid,
  input  logic            mem_ready,
  output logic            mem_read,
  output logic            mem_write,
  output logic            stall,
  output logic [IR_W-1:0] ir4,
  output logic            ir4_valid,
  output logic            mem_error
);

  mem_state_e      state_q;
  logic [IR_W-1:0] holdIr_q;
  logic [IR_W-1:0] ir4_q;
  logic            ir4Valid_q;
  logic            memRead_q;
  logic            memWrite_q;
  logic            memError_q;
  logic            timerExpired;
  logic [3:0]      opcode;

  assign opcode = ir3[3:0];
  assign stall  = (state_q == ST_ACCESS);

  // Counter is held at zero whenever idle, so each access starts fresh.
  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (state_q == ST_IDLE),
    .enable_i  ((state_q == ST_ACCESS) && !mem_ready),
    .expired_o (timerExpired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      holdIr_q   <= '0;
      ir4_q      <= '0;
      ir4Valid_q <= 1'b0;
      memRead_q  <= 1'b0;
      memWrite_q <= 1'b0;
      memError_q <= 1'b0;
    end else begin
      memError_q <= 1'b0;
      ir4Valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ir3_valid) begin
            if (isMemOp(opcode)) begin
              holdIr_q   <= ir3;
              memRead_q  <= (opcode == OP_LOAD);
              memWrite_q <= (opcode == OP_STORE);
              state_q    <= ST_ACCESS;
            end else begin
              ir4_q      <= ir3;
              ir4Valid_q <= 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          // A completing memory wins over a simultaneous timeout.
          if (mem_ready) begin
            memRead_q  <= 1'b0;
            memWrite_q <= 1'b0;
            ir4_q      <= holdIr_q;
            ir4Valid_q <= 1'b1;
            state_q    <= ST_IDLE;
          end else if (timerExpired) begin
            memRead_q  <= 1'b0;
            memWrite_q <= 1'b0;
            memError_q <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_read  = memRead_q;
  assign mem_write = memWrite_q;
  assign ir4       = ir4_q;
  assign ir4_valid = ir4Valid_q;
  assign mem_error = memError_q;

endmodule

// File: tb/tb_mem_stage_control.sv
// Scoreboard bench for mem_stage_control: expected ir4 values are queued when
// instructions are driven and compared whenever ir4_valid is seen.
module tb_mem_stage_control;

  localparam int IR_W    = 8;
  localparam int TIMEOUT = 8;

  logic            clock;
  logic            reset;
  logic [IR_W-1:0] ir3;
  logic            ir3_valid;
  logic            mem_ready;
  logic            mem_read;
  logic            mem_write;
  logic            stall;
  logic [IR_W-1:0] ir4;
  logic            ir4_valid;
  logic            mem_error;

  int              checkCount = 0;
  int              failCount  = 0;
  int              errorPulses = 0;
  logic [IR_W-1:0] expectedQ[$];

  mem_stage_control #(.IR_W(IR_W), .TIMEOUT(TIMEOUT)) dut (
    .clock     (clock),
    .reset     (reset),
    .ir3       (ir3),
    .ir3_valid (ir3_valid),
    .mem_ready (mem_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .stall     (stall),
    .ir4       (ir4),
    .ir4_valid (ir4_valid),
    .mem_error (mem_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [IR_W-1:0] instr, input logic valid,
                               input logic ready);
    ir3       = instr;
    ir3_valid = valid;
    mem_ready = ready;
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Scoreboard pop plus per-cycle invariants, sampled on the falling edge.
  always @(negedge clock) begin
    if (!reset) begin
      checkOutput("strobe_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
      if (mem_error) errorPulses++;
      if (ir4_valid) begin
        if (expectedQ.size() == 0) begin
          checkOutput("unexpected_ir4", {24'd0, ir4}, 32'hFFFF_FFFF);
        end else begin
          checkOutput("ir4_scoreboard", {24'd0, ir4}, {24'd0, expectedQ.pop_front()});
        end
      end
    end
  end

  // Issue a LOAD/STORE and follow it through ACCESS. readyAt is the ACCESS
  // cycle (1-based) in which mem_ready is raised; 0 means never.
  task automatic runMemOp(input string tag, input logic [IR_W-1:0] instr,
                          input int readyAt, input logic [IR_W-1:0] nextIr,
                          input logic nextValid);
    int   readCycles = 0;
    int   writeCycles = 0;
    int   stallCycles = 0;
    int   pulsesBefore;
    int   expCycles;
    logic isLoad;
    logic completes;
    logic done = 1'b0;
    isLoad    = (instr[3:0] == 4'b0000);
    completes = (readyAt >= 1) && (readyAt <= TIMEOUT);
    expCycles = completes ? readyAt : TIMEOUT;
    pulsesBefore = errorPulses;
    if (completes) expectedQ.push_back(instr);
    if (nextValid) expectedQ.push_back(nextIr);
    applyStimulus(instr, 1'b1, 1'b0);
    tick();
    applyStimulus(nextIr, nextValid, 1'b0);
    for (int c = 1; c <= TIMEOUT + 2 && !done; c++) begin
      if (mem_read)  readCycles++;
      if (mem_write) writeCycles++;
      if (stall)     stallCycles++;
      mem_ready = (c == readyAt);
      tick();
      mem_ready = 1'b0;
      if (!stall) done = 1'b1;
    end
    checkOutput({tag, "_left_access"}, {31'd0, done}, 32'd1);
    checkOutput({tag, "_read_cycles"}, readCycles, isLoad ? expCycles : 0);
    checkOutput({tag, "_write_cycles"}, writeCycles, isLoad ? 0 : expCycles);
    checkOutput({tag, "_stall_cycles"}, stallCycles, expCycles);
    checkOutput({tag, "_ir4_valid"}, {31'd0, ir4_valid}, {31'd0, completes});
    checkOutput({tag, "_mem_error"}, {31'd0, mem_error}, {31'd0, !completes});
    checkOutput({tag, "_strobes_off"}, {30'd0, mem_read, mem_write}, 32'd0);
    if (!nextValid) begin
      tick();
      checkOutput({tag, "_error_pulses"}, errorPulses - pulsesBefore, completes ? 0 : 1);
      checkOutput({tag, "_error_cleared"}, {31'd0, mem_error}, 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    applyStimulus('0, 1'b0, 1'b0);
    #12;
    checkOutput("reset_outputs", {19'd0, mem_read, mem_write, stall, ir4, ir4_valid, mem_error}, 32'd0);
    tick();
    reset = 1'b0;

    // Non-memory instruction, single-cycle latency.
    expectedQ.push_back(8'h15);
    applyStimulus(8'h15, 1'b1, 1'b0);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("nonmem_ir4_valid", {31'd0, ir4_valid}, 32'd1);
    checkOutput("nonmem_stall_strobes", {29'd0, stall, mem_read, mem_write}, 32'd0);
    tick();
    checkOutput("nonmem_valid_drops", {31'd0, ir4_valid}, 32'd0);
    checkOutput("idle_hold_ir4", {24'd0, ir4}, 32'h15);

    // mem_ready while idle must be ignored.
    applyStimulus(8'h00, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("idle_ready_ignored", {29'd0, stall, mem_read, mem_write}, 32'd0);
    applyStimulus(8'h00, 1'b0, 1'b0);

    runMemOp("load3", 8'h30, 3, 8'h00, 1'b0);
    runMemOp("store_timeout", 8'h42, 0, 8'h00, 1'b0);
    runMemOp("store_ready8", 8'h52, TIMEOUT, 8'h00, 1'b0);

    // Another non-memory opcode with upper bits set.
    expectedQ.push_back(8'hE1);
    applyStimulus(8'hE1, 1'b1, 1'b0);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0);
    tick();

    // Reset in the middle of an access aborts it without an error pulse.
    applyStimulus(8'h30, 1'b1, 1'b0);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("midreset_in_access", {30'd0, stall, mem_read}, 32'd3);
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset_outputs", {19'd0, mem_read, mem_write, stall, ir4, ir4_valid, mem_error}, 32'd0);
    tick();
    reset = 1'b0;
    expectedQ.push_back(8'h07);
    applyStimulus(8'h07, 1'b1, 1'b0);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("postreset_ir4_valid", {31'd0, ir4_valid}, 32'd1);
    checkOutput("postreset_no_error", {31'd0, mem_error}, 32'd0);
    tick();

    // LOAD followed by a non-memory instruction held by stall.
    runMemOp("b2b_load", 8'h10, 2, 8'h25, 1'b1);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("b2b_second_valid", {31'd0, ir4_valid}, 32'd1);
    tick();
    tick();
    checkOutput("b2b_no_duplicate", {31'd0, ir4_valid}, 32'd0);

    checkOutput("scoreboard_drained", expectedQ.size(), 32'd0);
    checkOutput("total_error_pulses", errorPulses, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_stage_control.md
MEM_STAGE_CONTROL -- requirements
Module: mem_stage_control

Interface
REQ-001 SHALL have parameter: IR_W, default 8, instruction register width.
REQ-002 SHALL have parameter: TIMEOUT, default 8, maximum ACCESS cycles before abort.
REQ-003 SHALL have port: clock  input  1  rising-edge clock.
REQ-004 SHALL have port: reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: ir3  input  IR_W  instruction from execute stage; opcode in ir3[3:0].
REQ-006 SHALL have port: ir3_valid  input  1  ir3 holds a real instruction.
REQ-007 SHALL have port: mem_ready  input  1  data memory has completed the current access.
REQ-008 SHALL have port: mem_read  output  1  registered data-memory read strobe.
REQ-009 SHALL have port: mem_write  output  1  registered data-memory write strobe.
REQ-010 SHALL have port: stall  output  1  combinational; upstream holds ir3/ir3_valid while high.
REQ-011 SHALL have port: ir4  output  IR_W  registered instruction handed to writeback control.
REQ-012 SHALL have port: ir4_valid  output  1  registered; ir4 is a real instruction this cycle.
REQ-013 SHALL have port: mem_error  output  1  registered one-cycle pulse on access timeout.

Function
REQ-014 SHALL decode opcodes: 4'b0000 LOAD (read), 4'b0010 STORE (write); all others non-memory.
REQ-015 SHALL implement states IDLE and ACCESS; stall = (state == ACCESS).
REQ-016 IDLE, ir3_valid=0 at edge: SHALL set ir4_valid<=0, hold ir4, stay IDLE.
REQ-017 IDLE, ir3_valid=1, non-memory opcode: SHALL set ir4<=ir3, ir4_valid<=1, stay IDLE (1-cycle latency).
REQ-018 IDLE, ir3_valid=1, LOAD/STORE: SHALL capture ir3 into hold register, set mem_read (LOAD) or mem_write (STORE) <=1, ir4_valid<=0, wait count<=0, go ACCESS.
REQ-019 ACCESS, mem_ready=1: SHALL clear mem_read/mem_write, set ir4<=hold, ir4_valid<=1, go IDLE.
REQ-020 ACCESS, mem_ready=0, count<TIMEOUT-1: SHALL keep strobe, ir4_valid<=0, count<=count+1.
REQ-021 ACCESS, mem_ready=0, count==TIMEOUT-1: SHALL clear strobes, ir4_valid<=0, pulse mem_error for one cycle, go IDLE (instruction dropped).
REQ-022 mem_ready and timeout on same edge: mem_ready SHALL win (normal completion, no mem_error).
REQ-023 mem_ready while IDLE SHALL be ignored.
REQ-024 ir3/ir3_valid SHALL be ignored while in ACCESS, including the completing edge; next instruction accepted on the following IDLE edge.
REQ-025 mem_read and mem_write SHALL never be high together.
REQ-026 wait count SHALL be ceil(log2(TIMEOUT)) bits wide, with no wrap past TIMEOUT-1.

Reset
REQ-027 On reset SHALL force state=IDLE, mem_read=0, mem_write=0, ir4=0, ir4_valid=0, mem_error=0, count=0, hold=0, regardless of clock.
REQ-028 Reset asserted during ACCESS SHALL abort the access immediately, with no mem_error pulse.
REQ-029 First edge after reset release SHALL behave as IDLE.

Structure
REQ-030 Opcode constants (OP_LOAD, OP_STORE), state encoding and TIMEOUT default SHALL live in shared package proc_ctrl_pkg.
REQ-031 Wait counter SHALL be one sub-module, mem_wait_timer (clear, enable, expired outputs).
REQ-032 All outputs except stall SHALL come directly from flops.

Verification
REQ-033 ir3=8'h15 (non-mem), valid 1 cycle -> next cycle ir4=8'h15, ir4_valid=1, stall=0, strobes 0.
REQ-034 ir3=8'h30 (LOAD), mem_ready high 3 cycles after issue -> mem_read high 3 cycles, stall high 3 cycles, then ir4=8'h30, ir4_valid=1.
REQ-035 ir3=8'h42 (STORE), mem_ready never -> mem_write high 8 cycles, mem_error single pulse, ir4_valid stays 0, state IDLE.
REQ-036 STORE with mem_ready first asserted on 8th ACCESS cycle -> completion, ir4_valid=1, mem_error=0.
REQ-037 LOAD issued, reset asserted mid-ACCESS -> all outputs 0 immediately; non-mem ir3=8'h07 after release -> ir4=8'h07 next cycle.
REQ-038 Back-to-back LOAD 8'h10 then non-mem 8'h25 held by stall -> ir4 sequence 8'h10, then 8'h25 one cycle later, no instruction lost or duplicated.
